// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Purpose  : Per-button front end for the cursor/run-control FSM: 2-flop
//            synchronizer, counter debounce, one-cycle press/release pulses,
//            and frame-paced auto-repeat while a button is held.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
    parameter int NUM_BTN             = 4,
    parameter int DEBOUNCE_CYCLES     = 250000,
    parameter int CNT_W               = 18,
    parameter int REPEAT_DELAY_FRAMES = 30,
    parameter int REPEAT_RATE_FRAMES  = 8,
    parameter int FRAME_CNT_W         = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_in,
    input  logic               frame_tick,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat,
    output logic [NUM_BTN-1:0] btn_action
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic [CNT_W-1:0]       DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FRAME_CNT_W-1:0] DELAY_LAST = FRAME_CNT_W'(REPEAT_DELAY_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] RATE_LAST  = FRAME_CNT_W'(REPEAT_RATE_FRAMES - 1);

    generate
        for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
            logic                   s1;
            logic                   s2;
            logic                   level;
            logic                   press_q;
            logic                   rel_q;
            logic                   rpt_q;
            logic [CNT_W-1:0]       cnt;
            logic [FRAME_CNT_W-1:0] fcnt;
            rep_state_t             state;
            logic                   accept;
            logic                   rise;
            logic                   fall;

            // The synchronized level has differed long enough: take it on this edge.
            assign accept = (s2 != level) && (cnt == DB_LAST);
            assign rise   = accept & s2;
            assign fall   = accept & ~s2;

            // Synchronize, debounce and emit the edge pulses on the acceptance edge.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1      <= 1'b0;
                    s2      <= 1'b0;
                    level   <= 1'b0;
                    cnt     <= '0;
                    press_q <= 1'b0;
                    rel_q   <= 1'b0;
                end else begin
                    s1      <= btn_in[i];
                    s2      <= s1;
                    press_q <= rise;
                    rel_q   <= fall;
                    if (s2 == level) begin
                        cnt <= '0;
                    end else if (cnt == DB_LAST) begin
                        level <= s2;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end

            // Auto-repeat FSM; a release on the same edge as a tick suppresses the repeat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= ST_IDLE;
                    fcnt  <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    case (state)
                        ST_IDLE: begin
                            if (rise) begin
                                state <= ST_DELAY;
                                fcnt  <= '0;
                            end
                        end
                        ST_DELAY: begin
                            if (fall) begin
                                state <= ST_IDLE;
                                fcnt  <= '0;
                            end else if (frame_tick) begin
                                if (fcnt == DELAY_LAST) begin
                                    rpt_q <= 1'b1;
                                    state <= ST_REPEAT;
                                    fcnt  <= '0;
                                end else begin
                                    fcnt <= fcnt + FRAME_CNT_W'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (fall) begin
                                state <= ST_IDLE;
                                fcnt  <= '0;
                            end else if (frame_tick) begin
                                if (fcnt == RATE_LAST) begin
                                    rpt_q <= 1'b1;
                                    fcnt  <= '0;
                                end else begin
                                    fcnt <= fcnt + FRAME_CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            state <= ST_IDLE;
                            fcnt  <= '0;
                        end
                    endcase
                end
            end

            assign btn_level[i]   = level;
            assign btn_press[i]   = press_q;
            assign btn_release[i] = rel_q;
            assign btn_repeat[i]  = rpt_q;
        end
    endgenerate

    assign btn_action = btn_press | btn_repeat;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_conditioner
// Purpose  : Self-checking bench for btn_conditioner: directed scenarios plus
//            random button activity against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_conditioner;

    localparam int NB = 4;
    localparam int DB = 4;
    localparam int DL = 3;
    localparam int RT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_in;
    logic          frame_tick;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat, btn_action;

    btn_conditioner #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(DB), .CNT_W(3),
        .REPEAT_DELAY_FRAMES(DL), .REPEAT_RATE_FRAMES(RT), .FRAME_CNT_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .frame_tick(frame_tick),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .btn_action(btn_action)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: pipeline delay, streak of differing samples, tick count since press.
    logic    m_d1 [NB];
    logic    m_d2 [NB];
    logic    m_lvl[NB];
    int      m_streak[NB];
    logic    m_held[NB];
    int      m_ticks[NB];
    logic [NB-1:0] m_press, m_rel, m_rep;

    int cnt_press[NB];
    int cnt_rel[NB];
    int cnt_rep[NB];
    int cnt_act[NB];

    bit auto_tick  = 1'b1;
    bit force_tick = 1'b0;
    int phase      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            m_d1[i] = 0; m_d2[i] = 0; m_lvl[i] = 0; m_streak[i] = 0;
            m_held[i] = 0; m_ticks[i] = 0;
        end
        m_press = '0; m_rel = '0; m_rep = '0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < NB; i++) begin
            m_press[i] = 0; m_rel[i] = 0; m_rep[i] = 0;
            if (m_d2[i] != m_lvl[i]) begin
                m_streak[i]++;
                if (m_streak[i] == DB) begin
                    m_lvl[i]    = m_d2[i];
                    m_streak[i] = 0;
                    if (m_lvl[i]) m_press[i] = 1; else m_rel[i] = 1;
                end
            end else begin
                m_streak[i] = 0;
            end
            if (m_press[i]) begin
                m_held[i] = 1; m_ticks[i] = 0;
            end else if (m_rel[i]) begin
                m_held[i] = 0; m_ticks[i] = 0;
            end else if (m_held[i] && frame_tick) begin
                m_ticks[i]++;
                if (m_ticks[i] >= DL && ((m_ticks[i] - DL) % RT) == 0) m_rep[i] = 1;
            end
            m_d2[i] = m_d1[i];
            m_d1[i] = btn_in[i];
        end
    endtask

    function automatic logic [NB-1:0] pack_lvl();
        logic [NB-1:0] v;
        for (int i = 0; i < NB; i++) v[i] = m_lvl[i];
        return v;
    endfunction

    // One clock cycle: drive tick, advance model, sample DUT 1 time unit after the edge.
    task automatic cycle();
        frame_tick = force_tick | (auto_tick && phase == 19);
        phase      = (phase + 1) % 20;
        @(posedge clk);
        model_step();
        #1;
        check("level",   32'(btn_level),   32'(pack_lvl()));
        check("press",   32'(btn_press),   32'(m_press));
        check("release", 32'(btn_release), 32'(m_rel));
        check("repeat",  32'(btn_repeat),  32'(m_rep));
        check("action",  32'(btn_action),  32'(m_press | m_rep));
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] += int'(btn_press[i]);
            cnt_rel[i]   += int'(btn_release[i]);
            cnt_rep[i]   += int'(btn_repeat[i]);
            cnt_act[i]   += int'(btn_action[i]);
        end
        force_tick = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int j = 0; j < n; j++) cycle();
    endtask

    task automatic tick_period();
        quiet(19);
        force_tick = 1'b1;
        cycle();
    endtask

    // Cycles until btn_press[idx] is seen (bounded); returns the cycle count.
    task automatic wait_press(input int idx, output int k);
        k = 0;
        do begin
            cycle();
            k++;
        end while (!btn_press[idx] && k < 40);
    endtask

    int k;

    initial begin
        for (int i = 0; i < NB; i++) begin
            cnt_press[i] = 0; cnt_rel[i] = 0; cnt_rep[i] = 0; cnt_act[i] = 0;
        end
        model_reset();
        rst_n      = 1'b0;
        btn_in     = 4'b0001;
        frame_tick = 1'b0;

        // Reset state with btn 0 already high.
        quiet(2);
        check("rst_level", 32'(btn_level), 32'h0);
        rst_n = 1'b1;

        // Level 0 rises on the 6th edge after reset release (capture edge + 5).
        k = 0;
        do begin cycle(); k++; end while (!btn_level[0] && k < 20);
        check("rst_rise_edges", 32'(k), 32'd6);
        check("rst_press_hi", 32'(btn_press[0]), 32'd1);
        cycle();
        check("rst_press_1cyc", 32'(btn_press[0]), 32'd0);
        check("rst_others", 32'(btn_level[3:1]), 32'h0);

        // Bounce on btn 1, then settle high.
        for (int j = 0; j < 8; j++) begin
            btn_in[1] = (j % 2 == 0);
            cycle();
        end
        check("bounce_no_press", 32'(cnt_press[1]), 32'd0);
        btn_in[1] = 1'b1;
        wait_press(1, k);
        check("bounce_settle_edges", 32'(k), 32'd6);
        quiet(10);
        check("bounce_press_cnt", 32'(cnt_press[1]), 32'd1);
        check("bounce_no_release", 32'(cnt_rel[1]), 32'd0);

        // Hold btn 2 for 10 ticks with manual tick placement.
        auto_tick  = 1'b0;
        cnt_rep[2] = 0;
        cnt_act[2] = 0;
        btn_in[2]  = 1'b1;
        wait_press(2, k);
        check("hold_press_edges", 32'(k), 32'd6);
        for (int t = 0; t < 10; t++) tick_period();
        check("hold_repeats", 32'(cnt_rep[2]), 32'd4);
        check("hold_actions", 32'(cnt_act[2]), 32'd5);

        // Release lands on the 11th tick, which would otherwise fire a repeat.
        btn_in[2] = 1'b0;
        quiet(5);
        force_tick = 1'b1;
        cycle();
        check("rel_pulse", 32'(btn_release[2]), 32'd1);
        check("rel_no_repeat", 32'(btn_repeat[2]), 32'd0);
        for (int t = 0; t < 4; t++) tick_period();
        check("rel_idle_repeats", 32'(cnt_rep[2]), 32'd4);
        check("rel_count", 32'(cnt_rel[2]), 32'd1);

        // Press on btn 3 coincides with a tick; that tick is not counted.
        btn_in[3] = 1'b1;
        quiet(5);
        force_tick = 1'b1;
        cycle();
        check("coin_press", 32'(btn_press[3]), 32'd1);
        cnt_rep[3] = 0;
        tick_period();
        tick_period();
        check("coin_no_rep_2nd", 32'(cnt_rep[3]), 32'd0);
        tick_period();
        check("coin_rep_3rd", 32'(cnt_rep[3]), 32'd1);

        // Asynchronous reset mid-REPEAT on btn 0 (held throughout).
        auto_tick = 1'b1;
        quiet(60);
        #4;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_level",   32'(btn_level),   32'h0);
        check("arst_press",   32'(btn_press),   32'h0);
        check("arst_release", 32'(btn_release), 32'h0);
        check("arst_repeat",  32'(btn_repeat),  32'h0);
        check("arst_action",  32'(btn_action),  32'h0);
        #2;
        rst_n = 1'b1;
        wait_press(0, k);
        check("arst_repress_edges", 32'(k), 32'd6);

        // Random button activity with periodic ticks.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 15) == 0) begin
                int b;
                b = int'($urandom_range(0, NB - 1));
                btn_in[b] = ~btn_in[b];
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global safety net so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
